// File: rtl/game_pkg.sv
// Shared constants for the guessing-game board: button indices,
// default bus widths and debounce lengths for hardware and simulation.
package game_pkg;

    localparam int BTN_START        = 0;
    localparam int BTN_GUESS        = 1;
    localparam int NBTN             = 3;
    localparam int SW_W             = 10;
    localparam int DB_CYCLES_50MHZ  = 500000;
    localparam int DB_CYCLES_SIM    = 4;

endpackage : game_pkg

// File: rtl/input_conditioner_if.sv
// Board-pin side and conditioned side of the input front end.
// The master drives the raw pins; the slave (the conditioner) drives the clean outputs.
interface input_conditioner_if #(
    parameter int NBTN = game_pkg::NBTN,
    parameter int SW_W = game_pkg::SW_W
);

    logic [NBTN-1:0] btn_n;
    logic [SW_W-1:0] sw;
    logic [NBTN-1:0] btn_level;
    logic [NBTN-1:0] btn_press;
    logic [NBTN-1:0] btn_release;
    logic [SW_W-1:0] sw_sync;
    logic [SW_W-1:0] sw_snap;
    logic            snap_valid;

    modport master (
        output btn_n,
        output sw,
        input  btn_level,
        input  btn_press,
        input  btn_release,
        input  sw_sync,
        input  sw_snap,
        input  snap_valid
    );

    modport slave (
        input  btn_n,
        input  sw,
        output btn_level,
        output btn_press,
        output btn_release,
        output sw_sync,
        output sw_snap,
        output snap_valid
    );

endinterface : input_conditioner_if

// File: rtl/debounce_cell.sv
// One push button: 2-flop synchroniser, debounce counter, clean level
// and one-cycle press/release strobes. press_next is high in the cycle
// before press_strobe so the parent can act on the same edge.
module debounce_cell #(
    parameter int DB_CYCLES = game_pkg::DB_CYCLES_SIM
) (
    input  logic Clock,
    input  logic Reset,
    input  logic raw_n,
    output logic level,
    output logic press_strobe,
    output logic release_strobe,
    output logic press_next
);

    localparam int CNT_W = $clog2(DB_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

    logic             s1;
    logic             s2;
    logic             sync;
    logic             expire;
    logic [CNT_W-1:0] cnt;

    assign sync       = ~s2;
    assign expire     = (sync != level) && (cnt == CNT_LAST);
    assign press_next = expire && !level;

    // Synchronise the raw pin, then count stable mismatches until the level flips.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            s1             <= 1'b1;
            s2             <= 1'b1;
            cnt            <= '0;
            level          <= 1'b0;
            press_strobe   <= 1'b0;
            release_strobe <= 1'b0;
        end else begin
            s1             <= raw_n;
            s2             <= s1;
            press_strobe   <= 1'b0;
            release_strobe <= 1'b0;
            if (sync == level) begin
                cnt <= '0;
            end else if (expire) begin
                level          <= ~level;
                cnt            <= '0;
                press_strobe   <= ~level;
                release_strobe <= level;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule : debounce_cell

// File: rtl/input_conditioner.sv
// Input front end: debounces every button, synchronises the switch bus
// and captures a switch snapshot when the guess button is pressed.
module input_conditioner
    import game_pkg::*;
#(
    parameter int NBTN      = game_pkg::NBTN,
    parameter int SW_W      = game_pkg::SW_W,
    parameter int DB_CYCLES = game_pkg::DB_CYCLES_50MHZ,
    parameter int SNAP_IDX  = BTN_GUESS
) (
    input  logic                Clock,
    input  logic                Reset,
    input_conditioner_if.slave  bus
);

    localparam logic [NBTN-1:0] SNAP_MASK = NBTN'(1) << SNAP_IDX;

    logic [NBTN-1:0] press_next;
    logic [SW_W-1:0] sw_s1;
    logic            snap_fire;

    assign snap_fire = |(press_next & SNAP_MASK);

    for (genvar i = 0; i < NBTN; i++) begin : g_btn
        debounce_cell #(
            .DB_CYCLES (DB_CYCLES)
        ) u_cell (
            .Clock          (Clock),
            .Reset          (Reset),
            .raw_n          (bus.btn_n[i]),
            .level          (bus.btn_level[i]),
            .press_strobe   (bus.btn_press[i]),
            .release_strobe (bus.btn_release[i]),
            .press_next     (press_next[i])
        );
    end

    // Two-flop synchroniser for the switches; the snapshot takes the synchronised value on a guess press.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            sw_s1          <= '0;
            bus.sw_sync    <= '0;
            bus.sw_snap    <= '0;
            bus.snap_valid <= 1'b0;
        end else begin
            sw_s1          <= bus.sw;
            bus.sw_sync    <= sw_s1;
            bus.snap_valid <= snap_fire;
            if (snap_fire) begin
                bus.sw_snap <= bus.sw_sync;
            end
        end
    end

endmodule : input_conditioner

// File: tb/tb_input_conditioner.sv
// Directed bench for input_conditioner with a short debounce length,
// plus a second instance with a one-cycle debounce.
module tb_input_conditioner;

    localparam int NBTN = 3;
    localparam int SW_W = 10;

    logic Clock = 1'b0;
    logic Reset;
    int   assertCount = 0;
    int   failCount   = 0;

    input_conditioner_if #(.NBTN(NBTN), .SW_W(SW_W)) bus ();
    input_conditioner_if #(.NBTN(NBTN), .SW_W(SW_W)) bus1 ();

    input_conditioner #(
        .NBTN(NBTN), .SW_W(SW_W), .DB_CYCLES(game_pkg::DB_CYCLES_SIM), .SNAP_IDX(1)
    ) dut (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (bus)
    );

    input_conditioner #(
        .NBTN(NBTN), .SW_W(SW_W), .DB_CYCLES(1), .SNAP_IDX(1)
    ) dut1 (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (bus1)
    );

    // Free-running clock.
    always #5 Clock = ~Clock;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Advance n rising edges, landing 1 time unit after the last one.
    task automatic applyStimulus(input int n);
        repeat (n) @(posedge Clock);
        #1;
    endtask

    logic bounce[10] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    logic sawLevel;
    logic sawPress;

    // Directed scenarios with hand-derived edge timing.
    initial begin
        Reset      = 1'b1;
        bus.btn_n  = '1;
        bus.sw     = '0;
        bus1.btn_n = '1;
        bus1.sw    = '0;
        applyStimulus(3);
        checkOutput("rst_level",   32'(bus.btn_level),   32'h0);
        checkOutput("rst_press",   32'(bus.btn_press),   32'h0);
        checkOutput("rst_release", 32'(bus.btn_release), 32'h0);
        checkOutput("rst_sw_sync", 32'(bus.sw_sync),     32'h0);
        checkOutput("rst_sw_snap", 32'(bus.sw_snap),     32'h0);
        checkOutput("rst_snap_v",  32'(bus.snap_valid),  32'h0);
        checkOutput("rst_level1",  32'(bus1.btn_level),  32'h0);
        Reset = 1'b0;
        applyStimulus(2);

        // Clean press of button 0.
        bus.btn_n[0] = 1'b0;
        applyStimulus(5);
        checkOutput("s1_level_early", 32'(bus.btn_level), 32'h0);
        applyStimulus(1);
        checkOutput("s1_level",   32'(bus.btn_level),   32'h1);
        checkOutput("s1_press",   32'(bus.btn_press),   32'h1);
        checkOutput("s1_release", 32'(bus.btn_release), 32'h0);
        checkOutput("s1_snap_v",  32'(bus.snap_valid),  32'h0);
        checkOutput("s1_sw_snap", 32'(bus.sw_snap),     32'h0);
        applyStimulus(1);
        checkOutput("s1_press_end", 32'(bus.btn_press), 32'h0);
        checkOutput("s1_level_hold", 32'(bus.btn_level), 32'h1);

        // Release of button 0.
        bus.btn_n[0] = 1'b1;
        applyStimulus(5);
        checkOutput("s3_level_early", 32'(bus.btn_level), 32'h1);
        applyStimulus(1);
        checkOutput("s3_level",   32'(bus.btn_level),   32'h0);
        checkOutput("s3_release", 32'(bus.btn_release), 32'h1);
        checkOutput("s3_press",   32'(bus.btn_press),   32'h0);
        applyStimulus(1);
        checkOutput("s3_release_end", 32'(bus.btn_release), 32'h0);

        // Bouncing contact never reaches a stable debounce window.
        sawLevel = 1'b0;
        sawPress = 1'b0;
        for (int i = 0; i < 16; i++) begin
            bus.btn_n[0] = (i < 10) ? bounce[i] : 1'b1;
            applyStimulus(1);
            sawLevel = sawLevel | bus.btn_level[0];
            sawPress = sawPress | bus.btn_press[0];
        end
        checkOutput("s2_bounce_level", 32'(sawLevel), 32'h0);
        checkOutput("s2_bounce_press", 32'(sawPress), 32'h0);

        // Guess press captures the switches; later switch moves do not disturb the snapshot.
        bus.sw = 10'h2A5;
        applyStimulus(3);
        bus.btn_n[1] = 1'b0;
        applyStimulus(5);
        checkOutput("s4_snap_v_early", 32'(bus.snap_valid), 32'h0);
        applyStimulus(1);
        checkOutput("s4_snap_v",  32'(bus.snap_valid), 32'h1);
        checkOutput("s4_sw_snap", 32'(bus.sw_snap),    32'h2A5);
        checkOutput("s4_press",   32'(bus.btn_press),  32'h2);
        bus.sw = 10'h0F0;
        applyStimulus(1);
        checkOutput("s4_snap_v_end", 32'(bus.snap_valid), 32'h0);
        applyStimulus(2);
        checkOutput("s4_sw_sync",      32'(bus.sw_sync),   32'h0F0);
        checkOutput("s4_sw_snap_hold", 32'(bus.sw_snap),   32'h2A5);
        checkOutput("s4_level_held",   32'(bus.btn_level), 32'h2);
        bus.btn_n[1] = 1'b1;
        applyStimulus(8);
        checkOutput("s4_level_rel",    32'(bus.btn_level), 32'h0);
        checkOutput("s4_sw_snap_rel",  32'(bus.sw_snap),   32'h2A5);

        // Reset while button 2 is mid-count; it re-debounces from scratch.
        bus.btn_n[2] = 1'b0;
        applyStimulus(4);
        Reset = 1'b1;
        applyStimulus(1);
        Reset = 1'b0;
        checkOutput("s5_level",   32'(bus.btn_level),   32'h0);
        checkOutput("s5_press",   32'(bus.btn_press),   32'h0);
        checkOutput("s5_release", 32'(bus.btn_release), 32'h0);
        checkOutput("s5_sw_sync", 32'(bus.sw_sync),     32'h0);
        checkOutput("s5_sw_snap", 32'(bus.sw_snap),     32'h0);
        checkOutput("s5_snap_v",  32'(bus.snap_valid),  32'h0);
        applyStimulus(5);
        checkOutput("s5_level_early", 32'(bus.btn_level), 32'h0);
        applyStimulus(1);
        checkOutput("s5_level_rise", 32'(bus.btn_level), 32'h4);
        checkOutput("s5_press_rise", 32'(bus.btn_press), 32'h4);
        applyStimulus(1);
        checkOutput("s5_press_end", 32'(bus.btn_press), 32'h0);
        bus.btn_n[2] = 1'b1;
        applyStimulus(8);
        checkOutput("s5_level_rel", 32'(bus.btn_level), 32'h0);

        // Buttons 0 and 1 pressed together.
        bus.btn_n[1:0] = 2'b00;
        applyStimulus(5);
        checkOutput("s6_press_early", 32'(bus.btn_press), 32'h0);
        applyStimulus(1);
        checkOutput("s6_press",   32'(bus.btn_press),  32'h3);
        checkOutput("s6_snap_v",  32'(bus.snap_valid), 32'h1);
        checkOutput("s6_sw_snap", 32'(bus.sw_snap),    32'h0F0);
        applyStimulus(1);
        checkOutput("s6_press_end",  32'(bus.btn_press),  32'h0);
        checkOutput("s6_snap_v_end", 32'(bus.snap_valid), 32'h0);

        // One-cycle debounce: level follows the synchronised pin one edge later.
        bus1.btn_n[0] = 1'b0;
        applyStimulus(2);
        checkOutput("db1_level_early", 32'(bus1.btn_level), 32'h0);
        applyStimulus(1);
        checkOutput("db1_level", 32'(bus1.btn_level), 32'h1);
        checkOutput("db1_press", 32'(bus1.btn_press), 32'h1);
        applyStimulus(1);
        checkOutput("db1_press_end", 32'(bus1.btn_press), 32'h0);
        bus1.btn_n[0] = 1'b1;
        applyStimulus(2);
        checkOutput("db1_rel_early", 32'(bus1.btn_level), 32'h1);
        applyStimulus(1);
        checkOutput("db1_rel_level", 32'(bus1.btn_level),   32'h0);
        checkOutput("db1_release",   32'(bus1.btn_release), 32'h1);
        applyStimulus(1);
        checkOutput("db1_release_end", 32'(bus1.btn_release), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule : tb_input_conditioner

// File: doc/input_conditioner.md
Name: input_conditioner

Overview:
Input front end for the guessing-game board. It turns raw, bouncing, active-low push buttons and raw slide switches into clean synchronous signals: a debounced level per button, one-cycle press and release strobes, and a 2-flop-synchronised switch bus. On a press of the designated "guess" button it also captures a stable snapshot of the switches. It sits between the board pins and the game state machine, guess counter and LFSR, so none of those blocks ever sample raw pins.

Parameters:
NBTN, 3, number of push buttons (index 0 Start, 1 Guess, 2 spare).
SW_W, 10, switch bus width.
DB_CYCLES, 500000, stable cycles required before a debounced level changes (10 ms at 50 MHz); legal range is 1 and above.
SNAP_IDX, 1, index of the button whose press captures the switches.
CNT_W, derived as clog2(DB_CYCLES+1), debounce counter width; not user-set.

Ports:
Clock  in  1  system clock; every flop is on its rising edge.
Reset  in  1  synchronous reset, active-high.
btn_n  in  NBTN  raw buttons, active-low (0 = pressed), asynchronous to Clock.
sw  in  SW_W  raw switches, asynchronous.
btn_level  out  NBTN  debounced level, active-high (1 = pressed).
btn_press  out  NBTN  one-cycle strobe on each debounced 0->1 of btn_level.
btn_release  out  NBTN  one-cycle strobe on each debounced 1->0 of btn_level.
sw_sync  out  SW_W  switches after the 2-flop synchroniser; not debounced.
sw_snap  out  SW_W  sw_sync value captured at the SNAP_IDX press.
snap_valid  out  1  one-cycle strobe, coincident with btn_press[SNAP_IDX].

Behaviour:
- Reset values:
  - Synchroniser flops for btn_n load 1 (released).
  - Synchroniser flops for sw load 0.
  - btn_level, btn_press, btn_release, sw_sync, sw_snap, snap_valid and all counters load 0.
- Reset dominates every other event on the same edge.
- Synchroniser:
  - Each btn_n bit passes through s1 then s2, and is inverted after s2 to give sync (active-high).
  - sw passes through the same 2-flop chain to give sw_sync.
- Debounce, per button and independent:
  - When sync == btn_level, cnt <= 0.
  - When sync != btn_level and cnt < DB_CYCLES-1, cnt <= cnt+1.
  - When sync != btn_level and cnt == DB_CYCLES-1, btn_level toggles and cnt <= 0.
- Latency:
  - Let edge k be the first edge whose s1 samples the new raw value.
  - If raw stays stable, btn_level changes at edge k+1+DB_CYCLES.
  - A raw pulse or glitch that lasts fewer than DB_CYCLES synchronised cycles produces no level change and no strobe. Any mismatch gap restarts the count.
- Strobes:
  - btn_press (or btn_release) is registered and goes high on the same edge btn_level rises (or falls).
  - The strobe is high for exactly one cycle.
  - Press and release are never both high for one button.
- Snapshot:
  - On the edge where btn_press[SNAP_IDX] goes high, sw_snap <= sw_sync (the value before that edge) and snap_valid goes high for one cycle.
  - sw_snap holds its value until the next snapshot or Reset. Switch changes while the button is held do not alter it.
- Simultaneous events: several buttons may strobe in the same cycle; each button's FSM is fully independent.
- Reset mid-operation:
  - Counters clear and levels drop to 0, with no release strobe generated.
  - A button held through reset produces a fresh btn_press once debounce completes after Reset deasserts, at edge R+2+DB_CYCLES, where R is the last edge with Reset high.
- DB_CYCLES = 1: btn_level follows sync with one cycle of delay; strobes still last one cycle.
- Counter saturation: the counter never exceeds DB_CYCLES-1 and never wraps.

Decomposition:
- Shared package game_pkg holds:
  - default constants BTN_START=0, BTN_GUESS=1, NBTN=3, SW_W=10, DB_CYCLES_50MHZ=500000;
  - simulation constant DB_CYCLES_SIM=4.
- One sub-module, debounce_cell: synchroniser, counter, level and strobes for a single bit, with parameter DB_CYCLES. It is instantiated NBTN times via generate.
- The switch synchroniser and snapshot register live in the top level.

Test Plan:
All scenarios use DB_CYCLES=4 and SNAP_IDX=1.
1. Reset, then drive btn_n[0]=0 so s1 samples it at edge 10, and hold -> btn_level[0]=1 from edge 15; btn_press[0]=1 only for the cycle after edge 15; no other outputs change.
2. Bounce: btn_n[0] low for 3 cycles, high for 1, low for 2, then high -> btn_level[0] stays 0; btn_press[0] never asserts.
3. Release: after scenario 1, drive btn_n[0]=1 (sampled at edge 30) -> btn_level[0] falls at edge 35; btn_release[0] pulses for one cycle; btn_press[0] stays 0.
4. Snapshot: sw=10'h2A5 held for 3 or more cycles, then press button 1 -> sw_snap=10'h2A5 and snap_valid=1 for one cycle together with btn_press[1]. Then set sw=10'h0F0 while held -> sw_snap stays 10'h2A5, sw_sync becomes 10'h0F0.
5. Reset mid-count: btn_n[2]=0 held; assert Reset for one cycle when cnt=2 (last Reset edge R=20) -> all outputs are 0 at edge 20; btn_level[2] rises and btn_press[2] pulses at edge 26.
6. Simultaneous: btn_n[0] and btn_n[1] fall on the same cycle -> btn_press[0], btn_press[1] and snap_valid all assert in the same single cycle.
